// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for uart_tx_arbiter.
// master = requesters/transmitter environment, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART transmitter, one output register.
// Optional per-requester accepted-byte counters when UART_ARB_STATS_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_arbiter_if.slave       bus
`ifdef UART_ARB_STATS_EN
    ,
    input  logic                   stats_clear,
    output logic [16*NUM_REQ-1:0]  byte_count
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [GW-1:0] rr_ptr_q;
    logic [GW-1:0] grant_id_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic [CW-1:0] tmo_cnt_q;

    logic [GW-1:0]      rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic [GW-1:0]      pick_d;
    logic               pick_found;
    logic [GW-1:0]      grant_inc;
    logic               holder_valid;
    logic               holder_last;
    logic [7:0]         holder_data;
    logic               tx_slot;
    logic               accept;

    // Rotate the request vector so position 0 is the round-robin pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [GW:0] sum;
        assign sum           = {1'b0, rr_ptr_q} + (GW+1)'(gi);
        assign rot_idx[gi]   = (sum >= (GW+1)'(NUM_REQ)) ? GW'(sum - (GW+1)'(NUM_REQ)) : sum[GW-1:0];
        assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
    end

    always_comb begin
        pick_found = 1'b0;
        pick_d     = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick_found = 1'b1;
                pick_d     = rot_idx[k];
            end
        end
    end

    assign grant_inc    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign holder_valid = bus.req_valid[grant_id_q];
    assign holder_last  = bus.req_last[grant_id_q];
    assign holder_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];
    assign tx_slot      = ~tx_valid_q | bus.tx_ready;
    assign accept       = (state_q == LOCKED) & holder_valid & tx_slot;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = (state_q == LOCKED) && (grant_id_q == GW'(gi)) && tx_slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            if (accept) begin
                tx_data_q  <= holder_data;
                tx_valid_q <= 1'b1;
            end else if (bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    if (pick_found) begin
                        grant_id_q <= pick_d;
                        state_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && holder_last) begin
                        state_q   <= IDLE;
                        rr_ptr_q  <= grant_inc;
                        tmo_cnt_q <= '0;
                    end else if (holder_valid) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        // Abandoned holder: release; any buffered byte still drains.
                        state_q   <= IDLE;
                        rr_ptr_q  <= grant_inc;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q == LOCKED) | tx_valid_q;

`ifdef UART_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [15:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst || stats_clear) begin
                cnt_q <= '0;
            end else if (accept && (grant_id_q == GW'(gi)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign byte_count[16*gi +: 16] = cnt_q;
    end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, LOCK_TIMEOUT=8); one line per checked item.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(2)) ifc ();

`ifdef UART_ARB_STATS_EN
    logic        stats_clear;
    logic [31:0] byte_count;
`endif

    uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef UART_ARB_STATS_EN
        ,
        .stats_clear (stats_clear),
        .byte_count  (byte_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] out_q[$];
    logic [1:0] rdy_s, vld_s;
    logic       rst_s;
    bit         en0 = 1'b1;
    bit         en1 = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        ifc.req_valid[0] = (q0.size() > 0) && en0;
        ifc.req_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        ifc.req_last[0]  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        ifc.req_valid[1] = (q1.size() > 0) && en1;
        ifc.req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        ifc.req_last[1]  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    // One clock: snapshot handshakes before the edge, update requesters after it, return at negedge.
    task automatic step();
        #1;
        rdy_s = ifc.req_ready;
        vld_s = ifc.req_valid;
        rst_s = rst;
        if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) out_q.push_back(ifc.tx_data);
        @(posedge clk);
        #1;
        if (rst_s !== 1'b1) begin
            if (vld_s[0] === 1'b1 && rdy_s[0] === 1'b1) void'(q0.pop_front());
            if (vld_s[1] === 1'b1 && rdy_s[1] === 1'b1) void'(q1.pop_front());
        end
        drive();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max, input string tag);
        int n = 0;
        logic done;
        do begin
            step();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (ifc.busy === 1'b0);
        end while (!done && n < max);
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ifc.tx_ready  = 1'b1;
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
`ifdef UART_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        step();
        step();
        check("rst_tx_valid", ifc.tx_valid, 0);
        check("rst_tx_data", ifc.tx_data, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_grant", ifc.grant_id, 0);
        check("rst_req_ready", ifc.req_ready, 0);
        rst = 1'b0;

        // T1: single three-byte packet from req0
        q0.push_back(9'h061); q0.push_back(9'h062); q0.push_back(9'h163);
        step();
        check("t1_idle_ready", ifc.req_ready, 2'b00);
        check("t1_idle_txv", ifc.tx_valid, 0);
        step();
        check("t1_ready", ifc.req_ready, 2'b01);
        check("t1_grant", ifc.grant_id, 0);
        step();
        check("t1_txv_lat2", ifc.tx_valid, 1);
        check("t1_b0", ifc.tx_data, 8'h61);
        step();
        check("t1_b1", ifc.tx_data, 8'h62);
        step();
        check("t1_b2", ifc.tx_data, 8'h63);
        check("t1_busy_drain", ifc.busy, 1);
        step();
        check("t1_txv_off", ifc.tx_valid, 0);
        check("t1_idle_busy", ifc.busy, 0);
        check("t1_count", out_q.size(), 3);
        check("t1_out2", out_q[2], 8'h63);

        // T2: both requesters, two 2-byte packets each, from rr_ptr=0
        rst = 1'b1; step(); rst = 1'b0;
        out_q.delete();
        q0.push_back(9'h0A0); q0.push_back(9'h1A1); q0.push_back(9'h0A2); q0.push_back(9'h1A3);
        q1.push_back(9'h0B0); q1.push_back(9'h1B1); q1.push_back(9'h0B2); q1.push_back(9'h1B3);
        run_until_idle(60, "t2_drain");
        check("t2_count", out_q.size(), 8);
        check("t2_o0", out_q[0], 8'hA0);
        check("t2_o1", out_q[1], 8'hA1);
        check("t2_o2", out_q[2], 8'hB0);
        check("t2_o3", out_q[3], 8'hB1);
        check("t2_o4", out_q[4], 8'hA2);
        check("t2_o5", out_q[5], 8'hA3);
        check("t2_o6", out_q[6], 8'hB2);
        check("t2_o7", out_q[7], 8'hB3);

        // T3: back-pressure mid-packet (rr_ptr=0 after req1's last packet)
        out_q.delete();
        q0.push_back(9'h0C0); q0.push_back(9'h0C1); q0.push_back(9'h0C2); q0.push_back(9'h1C3);
        step(); step(); step();
        check("t3_first", ifc.tx_data, 8'hC0);
        ifc.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", ifc.tx_valid, 1);
            check("t3_hold_data", ifc.tx_data, 8'hC0);
            check("t3_hold_ready", ifc.req_ready, 2'b00);
        end
        ifc.tx_ready = 1'b1;
        run_until_idle(30, "t3_drain");
        check("t3_count", out_q.size(), 4);
        check("t3_o1", out_q[1], 8'hC1);
        check("t3_o3", out_q[3], 8'hC3);

        // T4: timeout; req0 abandons its packet after one byte, req1 waits
        out_q.delete();
        en1 = 1'b0;
        q0.push_back(9'h0D0);
        q1.push_back(9'h1E0);
        step(); step(); step();
        check("t4_d0_out", ifc.tx_data, 8'hD0);
        en1 = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("t4_still_locked", ifc.busy, 1);
        check("t4_still_grant0", ifc.grant_id, 0);
        step();
        check("t4_released", ifc.busy, 0);
        step();
        check("t4_grant1", ifc.grant_id, 1);
        check("t4_ready1", ifc.req_ready, 2'b10);
        step();
        check("t4_e0_out", ifc.tx_data, 8'hE0);
        run_until_idle(20, "t4_drain");
        check("t4_o0", out_q[0], 8'hD0);
        check("t4_o1", out_q[1], 8'hE0);

        // T5: reset while a byte of req1 is buffered
        q1.push_back(9'h0F0); q1.push_back(9'h0F1); q1.push_back(9'h1F2);
        step(); step(); step();
        check("t5_pre_txv", ifc.tx_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_txv", ifc.tx_valid, 0);
        check("t5_busy", ifc.busy, 0);
        check("t5_grant", ifc.grant_id, 0);
        q1.delete();
        out_q.delete();
        q1.push_back(9'h047); q1.push_back(9'h148);
        step(); step();
        check("t5_grant1", ifc.grant_id, 1);
        run_until_idle(20, "t5_drain");
        check("t5_count", out_q.size(), 2);
        check("t5_o0", out_q[0], 8'h47);
        check("t5_o1", out_q[1], 8'h48);

`ifdef UART_ARB_STATS_EN
        // T6: per-requester byte counters, clear, saturation
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst", byte_count, 32'd0);
        for (int i = 0; i < 200; i++) q0.push_back({(i == 199), 8'(i)});
        for (int i = 0; i < 3; i++) q1.push_back({(i == 2), 8'(i)});
        run_until_idle(400, "t6_drain_a");
        check("t6_cnt0", byte_count[15:0], 16'd200);
        check("t6_cnt1", byte_count[31:16], 16'd3);
        stats_clear = 1'b1; step(); stats_clear = 1'b0;
        check("t6_clear", byte_count, 32'd0);
        out_q.delete();
        for (int i = 0; i < 70000; i++) q0.push_back({(i == 69999), 8'(i)});
        run_until_idle(72000, "t6_drain_b");
        check("t6_sat0", byte_count[15:0], 16'hFFFF);
        check("t6_sat1", byte_count[31:16], 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
